// File: rtl/mem_display_sequencer_if.sv
// mem_display_sequencer_if: memory read port (req/ack) between the display
// sequencer and the memory it browses. The sequencer drives the master side.
interface mem_display_sequencer_if #(
  parameter int unsigned ADDR_W = 16
) ();

  logic              mem_rd;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_ack;
  logic [15:0]       mem_rdata;

  modport master (
    output mem_rd,
    output mem_addr,
    input  mem_ack,
    input  mem_rdata
  );

  modport slave (
    input  mem_rd,
    input  mem_addr,
    output mem_ack,
    output mem_rdata
  );

endinterface

// File: rtl/mem_display_sequencer.sv
// mem_display_sequencer: walks a read address through memory, fetches each
// word over a req/ack handshake and holds the address/data pair on the
// seven-segment datapath for a programmable number of scan ticks.
// Optional feature: define SEQ_TIMEOUT_EN to bound the wait for mem_ack;
// a timed-out fetch shows 16'hEEEE and sets the sticky err flag.
module mem_display_sequencer #(
  parameter int unsigned ADDR_W      = 16,
  parameter int unsigned DWELL_TICKS = 480,
  parameter int unsigned TIMEOUT_CYC = 15
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       tick,
  input  logic                       load,
  input  logic                       step,
  input  logic                       run,
  input  logic                       dir,
  input  logic [ADDR_W-1:0]          start_addr,
  mem_display_sequencer_if.master    mem,
  output logic [15:0]                disp_addr,
  output logic [15:0]                disp_data,
  output logic                       disp_valid,
  output logic                       busy,
  output logic                       err
);

  localparam int unsigned DWELL_W = (DWELL_TICKS > 1) ? $clog2(DWELL_TICKS) : 1;
  localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(DWELL_TICKS - 1);

  // Reject parameter values the datapath cannot represent.
  if (ADDR_W < 1 || ADDR_W > 16 || DWELL_TICKS < 1 || TIMEOUT_CYC < 1) begin : g_param_check
    $error("mem_display_sequencer: illegal parameter value");
  end

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    SHOW  = 2'd2
  } state_t;

  state_t              state, state_nx;
  logic [ADDR_W-1:0]   addr_reg, addr_nx, addr_adv;
  logic [DWELL_W-1:0]  dwell_cnt, dwell_nx;
  logic                mem_rd_q, mem_rd_nx;
  logic                busy_nx;
  logic [15:0]         disp_addr_nx, disp_data_nx;
  logic                disp_valid_nx;

`ifdef SEQ_TIMEOUT_EN
  localparam int unsigned TMO_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);

  logic [TMO_W-1:0] tmo_cnt, tmo_nx;
  logic             err_q, err_nx;

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  assign mem.mem_rd   = mem_rd_q;
  assign mem.mem_addr = addr_reg;

  // Neighbouring address in the selected direction, wrapping modulo 2^ADDR_W.
  assign addr_adv = dir ? (addr_reg - ADDR_W'(1)) : (addr_reg + ADDR_W'(1));

  // Next-state and next-register values for the sequencer.
  always_comb begin
    state_nx      = state;
    addr_nx       = addr_reg;
    dwell_nx      = dwell_cnt;
    disp_addr_nx  = disp_addr;
    disp_data_nx  = disp_data;
    disp_valid_nx = disp_valid;
`ifdef SEQ_TIMEOUT_EN
    tmo_nx        = tmo_cnt;
    err_nx        = err_q;
`endif

    case (state)
      IDLE: begin
        if (load) begin
          addr_nx  = start_addr;
          state_nx = FETCH;
`ifdef SEQ_TIMEOUT_EN
          err_nx   = 1'b0;
`endif
        end else if (step) begin
          addr_nx  = addr_adv;
          state_nx = FETCH;
        end else if (run) begin
          state_nx = FETCH;
        end
      end

      FETCH: begin
        if (mem.mem_ack) begin
          disp_data_nx  = mem.mem_rdata;
          disp_addr_nx  = 16'(addr_reg);
          disp_valid_nx = 1'b1;
          dwell_nx      = '0;
          state_nx      = SHOW;
`ifdef SEQ_TIMEOUT_EN
        end else if (tmo_cnt == TMO_LAST) begin
          disp_data_nx  = 16'hEEEE;
          disp_addr_nx  = 16'(addr_reg);
          disp_valid_nx = 1'b1;
          dwell_nx      = '0;
          err_nx        = 1'b1;
          state_nx      = SHOW;
        end else begin
          tmo_nx        = tmo_cnt + TMO_W'(1);
`endif
        end
      end

      SHOW: begin
        if (load) begin
          addr_nx  = start_addr;
          state_nx = FETCH;
`ifdef SEQ_TIMEOUT_EN
          err_nx   = 1'b0;
`endif
        end else if (step) begin
          addr_nx  = addr_adv;
          dwell_nx = '0;
          state_nx = FETCH;
        end else if (!run) begin
          dwell_nx = '0;
        end else if (tick) begin
          if (dwell_cnt == DWELL_LAST) begin
            addr_nx  = addr_adv;
            dwell_nx = '0;
            state_nx = FETCH;
          end else begin
            dwell_nx = dwell_cnt + DWELL_W'(1);
          end
        end
      end

      default: state_nx = IDLE;
    endcase

    // Request and busy are asserted from the edge that enters FETCH.
    mem_rd_nx = (state_nx == FETCH);
    busy_nx   = (state_nx == FETCH);
`ifdef SEQ_TIMEOUT_EN
    if (state != FETCH) tmo_nx = '0;
`endif
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      addr_reg   <= '0;
      dwell_cnt  <= '0;
      mem_rd_q   <= 1'b0;
      busy       <= 1'b0;
      disp_addr  <= '0;
      disp_data  <= '0;
      disp_valid <= 1'b0;
`ifdef SEQ_TIMEOUT_EN
      tmo_cnt    <= '0;
      err_q      <= 1'b0;
`endif
    end else begin
      state      <= state_nx;
      addr_reg   <= addr_nx;
      dwell_cnt  <= dwell_nx;
      mem_rd_q   <= mem_rd_nx;
      busy       <= busy_nx;
      disp_addr  <= disp_addr_nx;
      disp_data  <= disp_data_nx;
      disp_valid <= disp_valid_nx;
`ifdef SEQ_TIMEOUT_EN
      tmo_cnt    <= tmo_nx;
      err_q      <= err_nx;
`endif
    end
  end

endmodule

// File: tb/tb_mem_display_sequencer.sv
// tb_mem_display_sequencer: directed + randomized bench for the memory
// display sequencer, checked against a transaction-level address/display model.
module tb_mem_display_sequencer;

  localparam int unsigned AW  = 16;
  localparam int unsigned DW  = 4;
  localparam int unsigned TO  = 15;
  localparam int unsigned MOD = 1 << AW;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          tick, load, step, run, dir;
  logic [AW-1:0] start_addr;
  logic [15:0]   disp_addr, disp_data;
  logic          disp_valid, busy, err;

  mem_display_sequencer_if #(.ADDR_W(AW)) mem_if ();

  mem_display_sequencer #(
    .ADDR_W      (AW),
    .DWELL_TICKS (DW),
    .TIMEOUT_CYC (TO)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .tick       (tick),
    .load       (load),
    .step       (step),
    .run        (run),
    .dir        (dir),
    .start_addr (start_addr),
    .mem        (mem_if),
    .disp_addr  (disp_addr),
    .disp_data  (disp_data),
    .disp_valid (disp_valid),
    .busy       (busy),
    .err        (err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: current address plus what the display should show.
  int unsigned m_addr;
  logic [15:0] m_daddr, m_ddata;
  logic        m_valid, m_err;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  function automatic int unsigned adv(input int unsigned a, input logic d);
    return d ? (a + MOD - 1) % MOD : (a + 1) % MOD;
  endfunction

  task automatic chk_disp(input string tag);
    chk({tag, "_daddr"}, 32'(disp_addr), 32'(m_daddr));
    chk({tag, "_ddata"}, 32'(disp_data), 32'(m_ddata));
    chk({tag, "_dvalid"}, 32'(disp_valid), 32'(m_valid));
    chk({tag, "_err"}, 32'(err), 32'(m_err));
  endtask

  task automatic expect_fetch(input string tag);
    chk({tag, "_rd"}, 32'(mem_if.mem_rd), 32'd1);
    chk({tag, "_busy"}, 32'(busy), 32'd1);
    chk({tag, "_maddr"}, 32'(mem_if.mem_addr), 32'(m_addr));
  endtask

  task automatic do_load(input logic [15:0] a);
    load = 1'b1; start_addr = a;
    cyc();
    load = 1'b0;
    m_addr = 32'(a); m_err = 1'b0;
    expect_fetch("load");
  endtask

  task automatic do_step(input logic d);
    step = 1'b1; dir = d;
    cyc();
    step = 1'b0;
    m_addr = adv(m_addr, d);
    expect_fetch("step");
  endtask

  // Answer the pending read after lat wait cycles; optionally poke commands
  // or ticks during the wait, and a colliding step on the ack cycle.
  task automatic serve(input int lat, input logic [15:0] data, input bit poke,
                       input bit collide, input bit tick_in);
    for (int i = 0; i < lat; i++) begin
      if (poke) begin
        load = 1'b1; step = 1'b1; start_addr = 16'(m_addr ^ 32'h5A5A);
      end
      tick = tick_in;
      cyc();
      load = 1'b0; step = 1'b0; tick = 1'b0;
      chk("wait_rd", 32'(mem_if.mem_rd), 32'd1);
      chk("wait_maddr", 32'(mem_if.mem_addr), 32'(m_addr));
      chk_disp("wait");
    end
    mem_if.mem_ack = 1'b1; mem_if.mem_rdata = data;
    step = collide; tick = tick_in;
    cyc();
    mem_if.mem_ack = 1'b0; mem_if.mem_rdata = 16'($urandom);
    step = 1'b0; tick = 1'b0;
    m_daddr = 16'(m_addr); m_ddata = data; m_valid = 1'b1;
    chk("ack_rd", 32'(mem_if.mem_rd), 32'd0);
    chk("ack_busy", 32'(busy), 32'd0);
    chk_disp("ack");
    if (collide) begin
      cyc();
      chk("collide_rd", 32'(mem_if.mem_rd), 32'd0);
    end
  endtask

  // One dwell period with run=1: DW-1 ticks do nothing, the DW-th fetches.
  task automatic dwell(input logic d);
    dir = d;
    for (int k = 1; k <= int'(DW); k++) begin
      for (int g = 0; g < int'($urandom_range(0, 2)); g++) begin
        cyc();
        chk("dwell_gap_rd", 32'(mem_if.mem_rd), 32'd0);
      end
      tick = 1'b1;
      cyc();
      tick = 1'b0;
      if (k < int'(DW)) begin
        chk("dwell_tick_rd", 32'(mem_if.mem_rd), 32'd0);
        chk_disp("dwell_hold");
      end
    end
    m_addr = adv(m_addr, d);
    expect_fetch("dwell_fetch");
  endtask

  initial begin
    reset_n = 1'b0;
    tick = 1'b0; load = 1'b0; step = 1'b0; run = 1'b0; dir = 1'b0;
    start_addr = '0;
    mem_if.mem_ack = 1'b0; mem_if.mem_rdata = '0;
    m_addr = 0; m_daddr = '0; m_ddata = '0; m_valid = 1'b0; m_err = 1'b0;

    // Reset values
    repeat (3) cyc();
    chk("rst_rd", 32'(mem_if.mem_rd), 32'd0);
    chk("rst_maddr", 32'(mem_if.mem_addr), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk_disp("rst");
    @(negedge clk) reset_n = 1'b1;
    cyc();

    // Load 0x0010, ack after two wait cycles
    do_load(16'h0010);
    serve(2, 16'hBEEF, 1'b0, 1'b0, 1'b0);
    chk("first_ddata", 32'(disp_data), 32'h0000BEEF);

    // Address wrap in both directions
    do_load(16'hFFFF);
    serve(0, 16'($urandom), 1'b0, 1'b0, 1'b0);
    do_step(1'b0);
    chk("wrap_up", 32'(mem_if.mem_addr), 32'h0000);
    serve(1, 16'($urandom), 1'b0, 1'b0, 1'b0);
    do_step(1'b1);
    chk("wrap_dn", 32'(mem_if.mem_addr), 32'hFFFF);
    serve(1, 16'($urandom), 1'b0, 1'b0, 1'b0);

    // load and step together: load wins; commands during FETCH dropped
    load = 1'b1; step = 1'b1; dir = 1'b0; start_addr = 16'h1234;
    cyc();
    load = 1'b0; step = 1'b0;
    m_addr = 32'h1234; m_err = 1'b0;
    expect_fetch("load_wins");
    serve(2, 16'($urandom), 1'b1, 1'b1, 1'b0);

    // Random command mix
    for (int it = 0; it < 24; it++) begin
      case ($urandom_range(0, 2))
        0: do_load(16'($urandom));
        1: do_step(1'($urandom));
        default: begin
          for (int g = 0; g < int'($urandom_range(1, 6)); g++) begin
            tick = 1'($urandom);
            cyc();
            tick = 1'b0;
            chk("idle_rd", 32'(mem_if.mem_rd), 32'd0);
            chk_disp("idle");
          end
          do_step(1'($urandom));
        end
      endcase
      serve(int'($urandom_range(0, 3)), 16'($urandom), 1'($urandom), 1'($urandom), 1'b0);
    end

    // Auto-run dwell; ticks during FETCH are ignored
    run = 1'b1;
    dwell(1'b0);
    serve(3, 16'($urandom), 1'b0, 1'b0, 1'b1);
    dwell(1'b1);
    serve(1, 16'($urandom), 1'b0, 1'b0, 1'b0);
    run = 1'b0;
    for (int g = 0; g < 8; g++) begin
      tick = 1'b1;
      cyc();
      tick = 1'b0;
      chk("frozen_rd", 32'(mem_if.mem_rd), 32'd0);
      chk_disp("frozen");
    end

`ifdef SEQ_TIMEOUT_EN
    // Fetch timeout: no ack for TO cycles
    do_load(16'($urandom));
    for (int i = 1; i < int'(TO); i++) begin
      cyc();
      chk("tmo_hold_rd", 32'(mem_if.mem_rd), 32'd1);
    end
    cyc();
    m_daddr = 16'(m_addr); m_ddata = 16'hEEEE; m_valid = 1'b1; m_err = 1'b1;
    chk("tmo_rd", 32'(mem_if.mem_rd), 32'd0);
    chk_disp("tmo");
    do_step(1'b0);
    serve(0, 16'($urandom), 1'b0, 1'b0, 1'b0);
    do_load(16'($urandom));
    chk("tmo_clear", 32'(err), 32'd0);
    serve(0, 16'($urandom), 1'b0, 1'b0, 1'b0);
`endif

    // Reset mid-fetch is immediate
    do_load(16'($urandom));
    reset_n = 1'b0;
    #1;
    m_addr = 0; m_daddr = '0; m_ddata = '0; m_valid = 1'b0; m_err = 1'b0;
    chk("arst_rd", 32'(mem_if.mem_rd), 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_maddr", 32'(mem_if.mem_addr), 32'd0);
    chk_disp("arst");
    @(negedge clk) reset_n = 1'b1;
    cyc();
    chk("post_rst_idle", 32'(mem_if.mem_rd), 32'd0);

    // run from IDLE fetches the current address
    run = 1'b1;
    cyc();
    run = 1'b0;
    expect_fetch("idle_run");
    serve(1, 16'($urandom), 1'b0, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_display_sequencer.md
# mem_display_sequencer

Sequences the memory-display path: steps a read address through memory, fetches each word over a req/ack handshake, and holds the address/data pair stable on the 8-digit seven-segment datapath for a programmable dwell time. Sits between the debounced button/switch inputs and the display mux/anode scanner: it supplies the 16-bit address (upper four digits) and 16-bit data (lower four digits) that the scanner multiplexes onto the digits.

## Interface
- ADDR_W, 16: memory address width (1–16); `disp_addr` is zero-extended to 16 bits
- DWELL_TICKS, 480: number of `tick` pulses per word in auto-run mode (≥1; 480 = 1 s at the 480 Hz scan rate)
- TIMEOUT_CYC, 15: maximum `clk` cycles to wait for `mem_ack` (only with `SEQ_TIMEOUT_EN`)

- clk  in  1  system clock; all logic on rising edge
- reset_n  in  1  asynchronous, active-low reset
- tick  in  1  one-`clk` pulse per scan period from the pixel clock divider
- load  in  1  one-cycle pulse; jump to `start_addr`
- step  in  1  one-cycle debounced pulse; advance one word
- run  in  1  level; 1 = auto-advance every DWELL_TICKS
- dir  in  1  0 = increment address, 1 = decrement
- start_addr  in  ADDR_W  address loaded on `load`
- mem_rd  out  1  read request, held until acknowledged
- mem_addr  out  ADDR_W  read address, stable while `mem_rd`=1
- mem_ack  in  1  read acknowledge; `mem_rdata` valid in the same cycle
- mem_rdata  in  16  read data
- disp_addr  out  16  address shown on digits 7–4
- disp_data  out  16  data shown on digits 3–0
- disp_valid  out  1  0 until the first fetch completes (scanner blanks all digits while 0)
- busy  out  1  1 in FETCH
- err  out  1  sticky fetch-timeout flag

## Operation
- States: IDLE, FETCH, SHOW.
- Reset: state IDLE; `addr_reg`, `mem_addr`, `disp_addr`, `disp_data`, and the dwell counter are 0; `mem_rd`, `disp_valid`, `busy`, and `err` are 0.
- IDLE:
  - `load` → `addr_reg`=`start_addr`, go to FETCH.
  - else `step` → `addr_reg`±1, go to FETCH.
  - else `run`=1 → FETCH at the current `addr_reg`.
- FETCH:
  - `mem_rd`=1, `mem_addr`=`addr_reg`, `busy`=1.
  - On an edge with `mem_ack`=1: `disp_data`←`mem_rdata`, `disp_addr`←`addr_reg`, `disp_valid`←1, `mem_rd`←0, dwell counter←0, go to SHOW.
  - `load` and `step` are ignored in FETCH (dropped, not queued).
- SHOW:
  - Command priority is `load` > `step` > dwell expiry.
  - `load` → reload the address and go to FETCH.
  - `step` → advance the address and go to FETCH; the dwell counter is cleared.
  - With `run`=1, each `tick` increments the dwell counter. On the tick at which the counter equals DWELL_TICKS−1, advance the address and go to FETCH.
  - With `run`=0, the counter holds at 0 and the word is displayed indefinitely.
- Address arithmetic is modulo 2^ADDR_W. Incrementing 2^ADDR_W−1 gives 0; decrementing 0 gives 2^ADDR_W−1. `dir` is sampled on the advancing edge.
- `disp_addr`/`disp_data` change only on a completed fetch (or on timeout). They never glitch mid-dwell.
- An asserted `reset_n` mid-fetch drops `mem_rd` immediately (asynchronously) and returns everything to reset values.

## Timing
- Trigger latency: a command at edge N puts the FSM in FETCH with `mem_rd`=1 from edge N.
- Read latency: with `mem_ack` high in the first FETCH cycle, the display updates and `mem_rd` falls at edge N+1. Each extra wait cycle adds one cycle.
- Back-to-back: a command arriving in the same cycle as the acknowledging `mem_ack` is ignored. The earliest next FETCH starts on the edge after the SHOW entry.
- Dwell time: DWELL_TICKS ticks from SHOW entry to the FETCH entry, with `tick` counted only in SHOW.
- A `tick` coincident with `step` is not counted.

## Configuration
- `SEQ_TIMEOUT_EN` defined:
  - FETCH counts cycles with `mem_rd`=1.
  - When TIMEOUT_CYC cycles elapse without `mem_ack`:
    - `mem_rd`←0;
    - `disp_data`←16'hEEEE, `disp_addr`←`addr_reg`, `disp_valid`←1;
    - `err`←1; go to SHOW.
  - `err` clears only on `load` or reset.
- Not defined:
  - FETCH waits for `mem_ack` indefinitely.
  - `err` is constant 0 and no timeout counter is synthesized.

## Test plan
- Reset, then `load` with `start_addr`=16'h0010 and ack after 2 cycles returning 16'hBEEF → `mem_rd` high 3 cycles; `disp_addr`=0010, `disp_data`=BEEF, `disp_valid`=1; `err`=0.
- From 16'hFFFF: `step` with `dir`=0 → fetch at 0000. From 0000: `step` with `dir`=1 → fetch at FFFF.
- `run`=1, DWELL_TICKS=4 → a new FETCH exactly on the 4th `tick` after SHOW entry; ticks during FETCH are not counted; `run`=0 freezes the display.
- `load` and `step` pulsed in the same SHOW cycle → `load` wins, `addr_reg`=`start_addr`. `step` during FETCH → ignored.
- `SEQ_TIMEOUT_EN` with `mem_ack` never asserted → `mem_rd` falls after 15 cycles, `disp_data`=EEEE, `err`=1; the next `load` clears `err`.
- Drive `reset_n` low mid-FETCH → `mem_rd` and `disp_valid` are 0 before the next edge; state is IDLE.
